// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu_pkg : shared opcodes, FSM state type and scan-length helper
// Revision    : 1.0
// ---------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [2:0] C_OP_SUB    = 3'b000;
  localparam logic [2:0] C_OP_NAND   = 3'b001;
  localparam logic [2:0] C_OP_LONES  = 3'b010;
  localparam logic [2:0] C_OP_OH2BIN = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int scan_len(input int width);
    return 2 * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu_scan : bit-serial scanner over {b,a}, MSB first; leading-ones count
//                plus lowest-set-bit index with multi-hot/empty tracking
// Revision     : 1.0
// ---------------------------------------------------------------------------
module seq_alu_scan
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(2 * WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [CW-1:0]    o_lones,
  output logic [CW-1:0]    o_index,
  output logic             o_seen,
  output logic             o_multi
);

  localparam int            SL     = scan_len(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(SL - 1);

  logic [SL-1:0] vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lones_q, lones_d;
  logic [CW-1:0] index_q, index_d;
  logic          run_q, run_d;
  logic          seen_q, seen_d;
  logic          multi_q, multi_d;
  logic          w_bit;

  assign w_bit = vec_q[SL-1];

  always_comb begin
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    lones_d = lones_q;
    index_d = index_q;
    run_d   = run_q;
    seen_d  = seen_q;
    multi_d = multi_q;
    if (i_start) begin
      vec_d   = {i_b, i_a};
      cnt_d   = '0;
      lones_d = '0;
      index_d = '0;
      run_d   = 1'b1;
      seen_d  = 1'b0;
      multi_d = 1'b0;
    end else if (i_en) begin
      vec_d = vec_q << 1;
      cnt_d = cnt_q + CW'(1);
      run_d = run_q & w_bit;
      if (run_q && w_bit) lones_d = lones_q + CW'(1);
      // Scanning from the MSB, the last set bit seen is the lowest one.
      if (w_bit) begin
        index_d = C_LAST - cnt_q;
        multi_d = multi_q | seen_q;
        seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      lones_q <= '0;
      index_q <= '0;
      run_q   <= 1'b0;
      seen_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      lones_q <= lones_d;
      index_q <= index_d;
      run_q   <= run_d;
      seen_q  <= seen_d;
      multi_q <= multi_d;
    end
  end

  // Next-state views let the top register the final bit's result directly.
  assign o_last  = (cnt_q == C_LAST);
  assign o_lones = lones_d;
  assign o_index = index_d;
  assign o_seen  = seen_d;
  assign o_multi = multi_d;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_alu  : sequential ALU with valid/ready handshake; SUB/NAND in one cycle,
//            LONES/OH2BIN via a 2*WIDTH-cycle bit-serial scan
// Revision : 1.0
// ---------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_overflow,
  output logic             o_err
);

  localparam int CW = $clog2(scan_len(WIDTH) + 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic                w_accept;
  logic                w_scan_op;
  logic                w_last;
  logic                w_seen;
  logic                w_multi;
  logic [CW-1:0]       w_lones;
  logic [CW-1:0]       w_index;
  logic [WIDTH-1:0]    w_diff;
  logic [CW+WIDTH-1:0] w_lones_ext;
  logic [CW+WIDTH-1:0] w_index_ext;

  assign w_accept    = i_valid && (state_q == ST_IDLE);
  assign w_scan_op   = (i_op == C_OP_LONES) || (i_op == C_OP_OH2BIN);
  assign w_diff      = a_q - b_q;
  assign w_lones_ext = {{WIDTH{1'b0}}, w_lones};
  assign w_index_ext = {{WIDTH{1'b0}}, w_index};

  seq_alu_scan #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_scan (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_accept && w_scan_op),
    .i_en    (state_q == ST_SCAN),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_last  (w_last),
    .o_lones (w_lones),
    .o_index (w_index),
    .o_seen  (w_seen),
    .o_multi (w_multi)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_valid) state_d = w_scan_op ? ST_SCAN : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_SCAN: if (w_last) state_d = ST_DONE;
      ST_DONE: if (i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    y_d   = y_q;
    ovf_d = ovf_q;
    err_d = err_q;
    if (w_accept) begin
      op_d = i_op;
      a_d  = i_a;
      b_d  = i_b;
    end
    if (state_q == ST_EXEC) begin
      case (op_q)
        C_OP_SUB: begin
          y_d   = w_diff;
          ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (w_diff[WIDTH-1] != a_q[WIDTH-1]);
          err_d = 1'b0;
        end
        C_OP_NAND: begin
          y_d   = ~(a_q & b_q);
          ovf_d = 1'b0;
          err_d = 1'b0;
        end
        default: begin
          y_d   = '0;
          ovf_d = 1'b0;
          err_d = 1'b1;
        end
      endcase
    end else if ((state_q == ST_SCAN) && w_last) begin
      if (op_q == C_OP_LONES) begin
        y_d   = w_lones_ext[WIDTH-1:0];
        ovf_d = |(w_lones_ext >> WIDTH);
        err_d = 1'b0;
      end else if (!w_seen) begin
        y_d   = '0;
        ovf_d = 1'b0;
        err_d = 1'b1;
      end else begin
        y_d   = w_index_ext[WIDTH-1:0];
        ovf_d = |(w_index_ext >> WIDTH);
        err_d = w_multi;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_valid    = (state_q == ST_DONE);
  assign o_y        = y_q;
  assign o_overflow = ovf_q;
  assign o_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_alu : directed vector bench for seq_alu at WIDTH=4 and WIDTH=2
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       valid = 1'b0;
  logic       rdy_in = 1'b1;
  logic [2:0] op = '0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       o_ready, o_valid, o_ovf, o_err;
  logic [3:0] o_y;

  logic       v2 = 1'b0;
  logic       rdy2 = 1'b1;
  logic [2:0] op2 = '0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       ready2, valid2, ovf2, err2;
  logic [1:0] y2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(o_valid), .i_ready(rdy_in),
    .o_y(o_y), .o_overflow(o_ovf), .o_err(o_err)
  );

  seq_alu #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(ready2),
    .i_op(op2), .i_a(a2), .i_b(b2), .o_valid(valid2), .i_ready(rdy2),
    .o_y(y2), .o_overflow(ovf2), .o_err(err2)
  );

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       ovf;
    logic       err;
    int         lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run4(input vec_t v);
    int cyc;
    check({v.name, "_ready"}, o_ready, 1);
    valid = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the DUT must have latched them.
    valid = 1'b0; op = ~v.op; a = ~v.a; b = ~v.b;
    cyc = 0;
    while (!o_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, "_lat"}, cyc, v.lat);
    check({v.name, "_res"}, {o_y, o_ovf, o_err}, {v.y, v.ovf, v.err});
    @(posedge clk); #1;
    check({v.name, "_hs"}, {o_valid, o_ready}, 2'b01);
  endtask

  task automatic run2(input string name, input logic [2:0] xop, input logic [1:0] xa,
                      input logic [1:0] xb, input logic [1:0] ey, input logic eovf,
                      input logic eerr, input int elat);
    int cyc;
    v2 = 1'b1; op2 = xop; a2 = xa; b2 = xb;
    @(posedge clk); #1;
    v2 = 1'b0;
    cyc = 0;
    while (!valid2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_lat"}, cyc, elat);
    check({name, "_res"}, {y2, ovf2, err2}, {ey, eovf, eerr});
    @(posedge clk); #1;
    check({name, "_hs"}, {valid2, ready2}, 2'b01);
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{"sub_ovf_neg",  3'b000, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1};
    vecs[1]  = '{"sub_pos",      3'b000, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1};
    vecs[2]  = '{"sub_to_neg",   3'b000, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1};
    vecs[3]  = '{"sub_ovf_pos",  3'b000, 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b0, 1};
    vecs[4]  = '{"nand_mix",     3'b001, 4'b1010, 4'b0110, 4'b1101, 1'b0, 1'b0, 1};
    vecs[5]  = '{"nand_ones",    3'b001, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1};
    vecs[6]  = '{"lones_6",      3'b010, 4'b1100, 4'b1111, 4'd6,    1'b0, 1'b0, 8};
    vecs[7]  = '{"lones_0",      3'b010, 4'b1111, 4'b0111, 4'd0,    1'b0, 1'b0, 8};
    vecs[8]  = '{"lones_8",      3'b010, 4'b1111, 4'b1111, 4'd8,    1'b0, 1'b0, 8};
    vecs[9]  = '{"oh_single",    3'b011, 4'b0100, 4'b0000, 4'd2,    1'b0, 1'b0, 8};
    vecs[10] = '{"oh_multi",     3'b011, 4'b0101, 4'b0000, 4'd0,    1'b0, 1'b1, 8};
    vecs[11] = '{"oh_none",      3'b011, 4'b0000, 4'b0000, 4'd0,    1'b0, 1'b1, 8};
    vecs[12] = '{"oh_top",       3'b011, 4'b0000, 4'b1000, 4'd7,    1'b0, 1'b0, 8};
    vecs[13] = '{"oh_b_multi",   3'b011, 4'b0010, 4'b1000, 4'd1,    1'b0, 1'b1, 8};
    vecs[14] = '{"rsv_111",      3'b111, 4'b1011, 4'b0110, 4'd0,    1'b0, 1'b1, 1};
    vecs[15] = '{"sub_pre_rst",  3'b000, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1};

    #2;
    check("rst4_outs", {o_ready, o_valid, o_y, o_ovf, o_err}, {1'b1, 1'b0, 4'b0, 1'b0, 1'b0});
    check("rst2_outs", {ready2, valid2, y2, ovf2, err2}, {1'b1, 1'b0, 2'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run4(vecs[i]);

    // Reset mid-LONES: outputs clear immediately and the request never completes.
    valid = 1'b1; op = 3'b010; a = 4'b1111; b = 4'b1111;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midrst_outs", {o_ready, o_valid, o_y, o_ovf, o_err}, {1'b1, 1'b0, 4'b0, 1'b0, 1'b0});
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | o_valid;
    end
    check("midrst_no_valid", {seen, o_ready}, 2'b01);

    // Backpressure on NAND with ignored request traffic while busy.
    rdy_in = 1'b0;
    valid = 1'b1; op = 3'b001; a = 4'b1010; b = 4'b0110;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; op = 3'b000; a = 4'b0000; b = 4'b1111;
      check("bp_hold", {o_valid, o_ready, o_y, o_ovf, o_err}, {1'b1, 1'b0, 4'b1101, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("bp_hold_end", {o_valid, o_y}, {1'b1, 4'b1101});
    rdy_in = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {o_valid, o_ready, o_y}, {1'b0, 1'b1, 4'b1101});

    // Reserved opcode followed by a back-to-back SUB.
    valid = 1'b1; op = 3'b101; a = 4'b0110; b = 4'b0011;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    check("rsv_101", {o_valid, o_y, o_ovf, o_err}, {1'b1, 4'b0, 1'b0, 1'b1});
    valid = 1'b1; op = 3'b000; a = 4'b0101; b = 4'b0011;
    @(posedge clk); #1;
    check("b2b_hs", {o_valid, o_ready}, 2'b01);
    @(posedge clk); #1;
    valid = 1'b0;
    check("b2b_acc", o_ready, 1'b0);
    @(posedge clk); #1;
    check("b2b_sub", {o_valid, o_y, o_ovf, o_err}, {1'b1, 4'b0010, 1'b0, 1'b0});
    @(posedge clk); #1;

    run2("w2_lones4", 3'b010, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 4);
    run2("w2_oh3",    3'b011, 2'b00, 2'b10, 2'b11, 1'b0, 1'b0, 4);
    run2("w2_sub",    3'b000, 2'b10, 2'b01, 2'b01, 1'b1, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width (>=2).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  block can accept a request.
REQ-006 SHALL have port i_op  input  3  opcode: 000 SUB, 001 NAND, 010 LONES, 011 OH2BIN, 1xx reserved.
REQ-007 SHALL have port i_a  input  WIDTH  operand A, two's complement where signed.
REQ-008 SHALL have port i_b  input  WIDTH  operand B, two's complement where signed.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  consumer accepts result.
REQ-011 SHALL have port o_y  output  WIDTH  result.
REQ-012 SHALL have port o_overflow  output  1  result not representable in WIDTH bits.
REQ-013 SHALL have port o_err  output  1  invalid operand or opcode.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC (single-cycle ops) or SCAN (iterative ops) -> DONE -> IDLE.
REQ-015 SHALL assert o_ready only in IDLE; request accepted on a rising edge with i_valid=1 and o_ready=1; operands and opcode latched then.
REQ-016 SHALL, for SUB/NAND/reserved, register the result and assert o_valid at the first edge after acceptance (latency 1).
REQ-017 SHALL, for LONES/OH2BIN, scan vector {i_b,i_a} one bit per cycle over exactly 2*WIDTH cycles, with o_valid asserted at edge N+2*WIDTH for acceptance at edge N; no early exit.
REQ-018 SHALL compute SUB as o_y=A-B mod 2^WIDTH; o_overflow=1 iff sign(A)!=sign(B) and sign(o_y)!=sign(A); o_err=0.
REQ-019 SHALL compute NAND as o_y=~(A&B); o_overflow=0; o_err=0.
REQ-020 SHALL compute LONES as the count of consecutive 1s from the MSB of {B,A}; o_y=count[WIDTH-1:0]; o_overflow=1 iff count>2^WIDTH-1; o_err=0.
REQ-021 SHALL compute OH2BIN as the index of the lowest set bit of {B,A}; o_y=index[WIDTH-1:0]; o_overflow=1 iff index>2^WIDTH-1.
REQ-022 SHALL set o_err=1 for OH2BIN when more than one bit is set (index = lowest) or no bit is set (o_y=0, o_overflow=0).
REQ-023 SHALL, for reserved opcodes, drive o_y=0, o_overflow=0, o_err=1.
REQ-024 SHALL hold o_valid, o_y, o_overflow and o_err stable in DONE until an edge with i_ready=1, then return to IDLE with o_valid=0.
REQ-025 SHALL retain o_y, o_overflow and o_err at their last values after the handshake until the next result is registered.
REQ-026 SHALL ignore i_valid, i_op, i_a and i_b whenever o_ready=0.
REQ-027 SHALL allow back-to-back operation: the earliest re-acceptance is the edge after the result handshake (o_ready rises in the same cycle o_valid falls).

Reset
REQ-028 SHALL, on i_rst=1 at any time including mid-scan, immediately force state IDLE, o_ready=1, o_valid=0, o_y=0, o_overflow=0, o_err=0, and clear the scan counter and accumulators.
REQ-029 SHALL discard any in-flight request on reset; no result is ever emitted for it.

Structure
REQ-030 SHALL take opcode constants, the FSM state type and the scan-length constant function (2*WIDTH) from shared package seq_alu_pkg.
REQ-031 SHALL place the bit-serial scanner (LONES counter and OH2BIN first-index/multi-hot tracker) in sub-module seq_alu_scan, parameterised by WIDTH.

Verification (WIDTH=4 unless stated)
REQ-032 SHALL test SUB A=4'b1000, B=4'b0001 -> o_y=4'b0111, o_overflow=1, o_err=0, o_valid 1 cycle after accept.
REQ-033 SHALL test LONES B=4'b1111, A=4'b1100 -> o_y=6, o_overflow=0, o_valid exactly 8 cycles after accept; repeat at WIDTH=2 with B=2'b11, A=2'b11 -> count 4, o_y=0, o_overflow=1.
REQ-034 SHALL test OH2BIN B=0, A=4'b0100 -> o_y=2, o_err=0; A=4'b0101 -> o_y=0, o_err=1; B=A=0 -> o_y=0, o_err=1.
REQ-035 SHALL test backpressure: NAND A=4'b1010, B=4'b0110 with i_ready=0 for 3 cycles -> o_valid=1 and o_y=4'b1101 held stable, o_ready=0; completes on the first i_ready=1 edge.
REQ-036 SHALL test reset asserted mid-LONES at scan cycle 3 -> all outputs 0, o_ready=1 immediately, no o_valid pulse after release.
REQ-037 SHALL test opcode 3'b101 -> o_y=0, o_err=1 after 1 cycle; then a back-to-back SUB accepted on the edge after the handshake.
